// File: rtl/mc0512_pkg.sv
// mc0512_pkg: shared region/FSM types and the address decode helper for the mc0512 bus responder.
package mc0512_pkg;

   localparam int BUS_AW = 20;

   typedef enum logic [1:0] {
      REG_RAM = 2'd0,
      REG_IO  = 2'd1,
      REG_EXT = 2'd2
   } region_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } ext_state_t;

   // Port cycles win over memory; memory below 2**ram_aw is on-chip.
   function automatic region_t decode_region(input logic pr,
                                             input logic pw,
                                             input logic [BUS_AW-1:0] addr,
                                             input int ram_aw);
      region_t r;
      if (pr || pw) begin
         r = REG_IO;
      end else if ((addr >> ram_aw) == {BUS_AW{1'b0}}) begin
         r = REG_RAM;
      end else begin
         r = REG_EXT;
      end
      return r;
   endfunction

endpackage

// File: rtl/mc0512_ram.sv
// mc0512_ram: single-port synchronous byte RAM; a write and read of the same
// address on one edge returns the previous contents.
module mc0512_ram
   import mc0512_pkg::*;
#(
   parameter int AW = 16
) (
   input  logic          clock,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [0:(1<<AW)-1];
   logic [7:0] rdata_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (en) begin
         rdata_q <= mem_q[addr];
         if (we) begin
            mem_q[addr] <= wdata;
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mc0512_bus.sv
// mc0512_bus: K8088 bus target -- on-chip RAM, external memory req/ack port and I/O strobes.
// Optional external-wait watchdog is compiled in with MC0512_BUS_WDOG_EN.
module mc0512_bus
   import mc0512_pkg::*;
#(
   parameter int RAM_AW     = 16,
   parameter int IO_AW      = 16,
   parameter int WDOG_LIMIT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [BUS_AW-1:0] address,
   input  logic [7:0]        out,
   input  logic              we,
   input  logic              pr,
   input  logic              pw,
   output logic [7:0]        in,
   output logic              ce,
   output logic [BUS_AW-1:0] ext_address,
   output logic [7:0]        ext_wdata,
   output logic              ext_we,
   output logic              ext_req,
   input  logic [7:0]        ext_rdata,
   input  logic              ext_ack,
   output logic [IO_AW-1:0]  io_port,
   output logic [7:0]        io_wdata,
   output logic              io_rd,
   output logic              io_wr,
   input  logic [7:0]        io_rdata,
   output logic              bus_err
);

   region_t           region_s;
   logic              ce_s;
   logic              ram_en_s;
   logic              ram_we_s;
   logic [7:0]        ram_rdata_s;

   ext_state_t        state_q, state_d;
   logic [7:0]        in_q, in_d;
   logic              ram_sel_q, ram_sel_d;
   logic [BUS_AW-1:0] ext_address_q, ext_address_d;
   logic [7:0]        ext_wdata_q, ext_wdata_d;
   logic              ext_we_q, ext_we_d;
   logic              ext_req_q, ext_req_d;
`ifdef MC0512_BUS_WDOG_EN
   localparam logic [7:0] WDOG_LAST = 8'(WDOG_LIMIT - 1);
   logic [7:0]        wdog_q, wdog_d;
   logic              bus_err_q, bus_err_d;
`endif

   assign region_s = decode_region(pr, pw, address, RAM_AW);

   // Core stall: only an external access being issued or awaited holds the core.
   always_comb begin
      ce_s = 1'b1;
      case (state_q)
         IDLE:    ce_s = (region_s != REG_EXT);
         WAIT:    ce_s = 1'b0;
         DONE:    ce_s = 1'b1;
         default: ce_s = 1'b1;
      endcase
   end

   assign ram_en_s = ce_s && (region_s == REG_RAM);
   assign ram_we_s = ram_en_s && we;

   mc0512_ram #(
      .AW (RAM_AW)
   ) u_ram (
      .clock (clock),
      .en    (ram_en_s),
      .we    (ram_we_s),
      .addr  (address[RAM_AW-1:0]),
      .wdata (out),
      .rdata (ram_rdata_s)
   );

   // Next-state for read data selection, external handshake and watchdog.
   always_comb begin
      state_d       = state_q;
      in_d          = in_q;
      ram_sel_d     = ram_sel_q;
      ext_address_d = ext_address_q;
      ext_wdata_d   = ext_wdata_q;
      ext_we_d      = ext_we_q;
      ext_req_d     = ext_req_q;
`ifdef MC0512_BUS_WDOG_EN
      wdog_d        = wdog_q;
      bus_err_d     = bus_err_q;
`endif
      // in is driven either by the RAM output register or by in_q; ram_sel_q picks.
      if (ram_en_s) begin
         ram_sel_d = 1'b1;
      end else if (ce_s && pr) begin
         in_d      = io_rdata;
         ram_sel_d = 1'b0;
      end else begin
         ram_sel_d = ram_sel_q;
      end

      case (state_q)
         IDLE: begin
            if (region_s == REG_EXT) begin
               ext_address_d = address;
               ext_wdata_d   = out;
               ext_we_d      = we;
               ext_req_d     = 1'b1;
               state_d       = WAIT;
`ifdef MC0512_BUS_WDOG_EN
               wdog_d        = 8'd0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (ext_ack) begin
               in_d      = ext_rdata;
               ram_sel_d = 1'b0;
               ext_req_d = 1'b0;
               state_d   = DONE;
            end
`ifdef MC0512_BUS_WDOG_EN
            else if (wdog_q == WDOG_LAST) begin
               in_d      = 8'hFF;
               ram_sel_d = 1'b0;
               ext_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               wdog_d = wdog_q + 8'd1;
            end
`else
            else begin
               state_d = WAIT;
            end
`endif
         end
         // One released cycle; no request may be issued from here.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset also drops ext_req asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         in_q          <= 8'hFF;
         ram_sel_q     <= 1'b0;
         ext_address_q <= {BUS_AW{1'b0}};
         ext_wdata_q   <= 8'h00;
         ext_we_q      <= 1'b0;
         ext_req_q     <= 1'b0;
`ifdef MC0512_BUS_WDOG_EN
         wdog_q        <= 8'd0;
         bus_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         in_q          <= in_d;
         ram_sel_q     <= ram_sel_d;
         ext_address_q <= ext_address_d;
         ext_wdata_q   <= ext_wdata_d;
         ext_we_q      <= ext_we_d;
         ext_req_q     <= ext_req_d;
`ifdef MC0512_BUS_WDOG_EN
         wdog_q        <= wdog_d;
         bus_err_q     <= bus_err_d;
`endif
      end
   end

   assign in          = ram_sel_q ? ram_rdata_s : in_q;
   assign ce          = ce_s;
   assign ext_address = ext_address_q;
   assign ext_wdata   = ext_wdata_q;
   assign ext_we      = ext_we_q;
   assign ext_req     = ext_req_q;
   assign io_port     = address[IO_AW-1:0];
   assign io_wdata    = out;
   assign io_rd       = pr & ce_s;
   assign io_wr       = pw & ~pr & ce_s;
`ifdef MC0512_BUS_WDOG_EN
   assign bus_err     = bus_err_q;
`else
   assign bus_err     = 1'b0;
`endif

endmodule
